// File: rtl/carry_pkg.sv
// Shared types and constants for the pipelined carry-chain add/subtract unit.
package carry_pkg;

    // Operation select encoding on the op port.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_INC = 2'b11
    } op_t;

    // Bit positions inside the flags bus, which reads {N, V, Z, C}.
    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_V = 2;
    localparam int F_N = 3;

endpackage

// File: rtl/carry_slice.sv
// Generic N-bit mux/XOR ripple-carry slice, purely combinational.
// Each bit either passes the incoming carry (propagate) or takes the
// generate input, and the sum bit is the propagate XOR the carry below it.
module carry_slice #(
    parameter int N = 4
) (
    input  logic         ci,
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    output logic [N-1:0] co,
    output logic [N-1:0] s
);

    // chain[i] is the carry entering bit i; chain[0] is the slice carry in.
    logic [N:0] chain;

    assign chain[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign co[i]      = p[i] ? chain[i] : g[i];
        assign s[i]       = p[i] ^ chain[i];
        assign chain[i+1] = co[i];
    end

endmodule

// File: rtl/carry_pipe.sv
// Pipelined add/subtract unit: operand select, a chain of carry_slice
// instances with one register rank after each, a global-stall valid/ready
// handshake and 6502-style N/V/Z/C flags taken from the final rank.
module carry_pipe
    import carry_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SLICE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int NSTAGES = WIDTH / SLICE_BITS;
    localparam int LAST    = NSTAGES - 1;

    if ((SLICE_BITS < 1) || (WIDTH % SLICE_BITS != 0)) begin : g_bad_geometry
        $error("carry_pipe: WIDTH must be a non-zero multiple of SLICE_BITS");
    end

    // Effective operands after op decode.
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Register ranks: index j holds rank j+1.
    logic [WIDTH-1:0] rk_a [NSTAGES];
    logic [WIDTH-1:0] rk_b [NSTAGES];
    logic [WIDTH-1:0] rk_s [NSTAGES];
    logic             rk_c [NSTAGES];
    logic [NSTAGES-1:0] rk_v;
    logic [3:0]       flags_q;

    // Inputs seen by slice k, and the values slice k hands to rank k+1.
    logic [WIDTH-1:0] st_a [NSTAGES];
    logic [WIDTH-1:0] st_b [NSTAGES];
    logic [WIDTH-1:0] st_s [NSTAGES];
    logic             st_c [NSTAGES];
    logic [WIDTH-1:0] nx_s [NSTAGES];
    logic             nx_c [NSTAGES];
    logic             nx_cm [NSTAGES];

    logic [3:0]       flags_nx;
    logic             adv;

    // Whole pipe advances together; a held result blocks everything behind it.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = rk_v[LAST];
    assign sum       = rk_s[LAST];
    assign flags     = flags_q;

    // Operand select: invert b for subtract/compare, force carry for CMP/INC.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        a_eff = a;
        b_eff = b;
        c_eff = ci;
        unique case (op_t'(op))
            OP_ADD: b_eff = b;
            OP_SUB: b_eff = ~b;
            OP_CMP: begin
                b_eff = ~b;
                c_eff = 1'b1;
            end
            OP_INC: begin
                b_eff = '0;
                c_eff = 1'b1;
            end
            default: b_eff = b;
        endcase
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] ONES = (WIDTH'(1) << SLICE_BITS) - WIDTH'(1);
        localparam logic [WIDTH-1:0] LANE = ONES << (k * SLICE_BITS);

        logic [SLICE_BITS-1:0] p;
        logic [SLICE_BITS-1:0] g;
        logic [SLICE_BITS-1:0] co;
        logic [SLICE_BITS-1:0] s;
        logic [SLICE_BITS:0]   cv;

        if (k == 0) begin : g_head
            assign st_a[k] = a_eff;
            assign st_b[k] = b_eff;
            assign st_s[k] = '0;
            assign st_c[k] = c_eff;
        end else begin : g_body
            assign st_a[k] = rk_a[k-1];
            assign st_b[k] = rk_b[k-1];
            assign st_s[k] = rk_s[k-1];
            assign st_c[k] = rk_c[k-1];
        end

        assign p = st_a[k][k*SLICE_BITS +: SLICE_BITS] ^ st_b[k][k*SLICE_BITS +: SLICE_BITS];
        assign g = st_a[k][k*SLICE_BITS +: SLICE_BITS];

        carry_slice #(
            .N (SLICE_BITS)
        ) u_slice (
            .ci (st_c[k]),
            .g  (g),
            .p  (p),
            .co (co),
            .s  (s)
        );

        // Merge this slice's sum bits into the partial sum; keep both the
        // carry out and the carry into the top bit of the slice (for V).
        assign cv       = {co, st_c[k]};
        assign nx_s[k]  = (st_s[k] & ~LANE) | (WIDTH'(s) << (k * SLICE_BITS));
        assign nx_c[k]  = cv[SLICE_BITS];
        assign nx_cm[k] = cv[SLICE_BITS-1];
    end

    // Flags for the result about to enter the final rank.
    always_comb begin
        flags_nx        = '0;
        flags_nx[F_C]   = nx_c[LAST];
        flags_nx[F_V]   = nx_c[LAST] ^ nx_cm[LAST];
        flags_nx[F_Z]   = (nx_s[LAST] == '0);
        flags_nx[F_N]   = nx_s[LAST][WIDTH-1];
    end

    // Data ranks: shift operands, partial sums and carries on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data ranks are reset as well so sum and flags read 0 out of reset.
            for (int j = 0; j < NSTAGES; j++) begin
                rk_a[j] <= '0;
                rk_b[j] <= '0;
                rk_s[j] <= '0;
                rk_c[j] <= 1'b0;
            end
            flags_q <= '0;
        end else if (adv) begin
            // NOTE: non-blocking so every rank samples the pre-edge value of the rank before it.
            for (int j = 0; j < NSTAGES; j++) begin
                rk_a[j] <= st_a[j];
                rk_b[j] <= st_b[j];
                rk_s[j] <= nx_s[j];
                rk_c[j] <= nx_c[j];
            end
            flags_q <= flags_nx;
        end
    end

    // Valid bits: flush wins over everything, including a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_v <= '0;
        end else if (flush) begin
            rk_v <= '0;
        end else if (adv) begin
            rk_v <= (rk_v << 1) | NSTAGES'(in_valid);
        end
    end

endmodule

// File: tb/tb_carry_pipe.sv
// Directed self-checking bench for carry_pipe at WIDTH=16, SLICE_BITS=4.
module tb_carry_pipe;

    localparam int WIDTH = 16;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [1:0]       op        = 2'b00;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             ci        = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] s;
        logic [3:0]       f;   // {N, V, Z, C}
    } vec_t;

    // Hand-computed vectors.
    vec_t vecs [8] = '{
        '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'h0},  // ADD, carry across slice 1
        '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'h3},  // ADD wraps: Z, C
        '{2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'h5},  // SUB: V, C
        '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'h5},  // CMP ignores ci
        '{2'b11, 16'h7FFF, 16'h1234, 1'b0, 16'h8000, 4'hC},  // INC: N, V
        '{2'b00, 16'h1234, 16'h4321, 1'b1, 16'h5556, 4'h0},  // ADD with ci
        '{2'b01, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'h8},  // SUB borrow: N only
        '{2'b01, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'h1}   // SUB with borrow in: C
    };

    carry_pipe #(
        .WIDTH      (16),
        .SLICE_BITS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i);
        op       = vecs[i].op;
        a        = vecs[i].a;
        b        = vecs[i].b;
        ci       = vecs[i].ci;
        in_valid = 1'b1;
    endtask

    // One isolated operation: result must appear after the 4th edge, not earlier.
    task automatic run_one(input int i);
        out_ready = 1'b1;
        drive(i);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("lat_wait", out_valid, 1'b0);
            step();
        end
        check("lat_valid", out_valid, 1'b1);
        check($sformatf("sum_v%0d", i), sum, vecs[i].s);
        check($sformatf("flags_v%0d", i), flags, vecs[i].f);
        step();
        check("drained", out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order [6] = '{5, 6, 7, 0, 1, 2};
        int exp_q [$];
        int n_sent;
        int n_got;
        int stalls;
        int seen;
        logic was_stall;
        logic [WIDTH-1:0] held_sum;
        logic [3:0] held_flags;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_flags", flags, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single operations with latency and flag checks.
        for (int i = 0; i < 5; i++) run_one(i);

        // Back-to-back stream with the consumer stalled in cycles 4..7.
        n_sent    = 0;
        n_got     = 0;
        stalls    = 0;
        was_stall = 1'b0;
        held_sum  = '0;
        held_flags = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (n_sent < 6) drive(order[n_sent]);
            else in_valid = 1'b0;
            #1;
            check("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (was_stall) begin
                check("stall_hold_sum", sum, held_sum);
                check("stall_hold_flags", flags, held_flags);
            end
            was_stall  = out_valid && !out_ready;
            held_sum   = sum;
            held_flags = flags;
            if (was_stall) stalls++;
            if (out_valid && out_ready) begin
                n_got++;
                if (exp_q.size() > 0) begin
                    int e;
                    e = exp_q.pop_front();
                    check($sformatf("stream_sum_v%0d", e), sum, vecs[e].s);
                    check($sformatf("stream_flags_v%0d", e), flags, vecs[e].f);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(order[n_sent]);
                n_sent++;
            end
            step();
        end
        in_valid = 1'b0;
        check("stream_count", n_got, 6);
        check("stream_stall_seen", stalls > 0, 1'b1);

        // Asynchronous reset with three operations in flight.
        out_ready = 1'b1;
        drive(5);
        step();
        drive(6);
        step();
        drive(7);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_sum", sum, 16'h0000);
        check("async_rst_flags", flags, 4'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen++;
        end
        check("post_rst_no_result", seen, 0);

        // Flush with two in flight plus one offered in the flush cycle.
        drive(0);
        step();
        drive(1);
        step();
        drive(2);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("post_flush_no_result", seen, 0);
        run_one(7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_pipe.md
# carry_pipe

Parametrised, pipelined add/subtract unit built from a chain of generic N-bit ripple-carry slices, with one register rank between slices and a valid/ready handshake at both ends. It generalises the four-bit mux/XOR carry primitive to arbitrary width and depth. It is intended for wide address/counter arithmetic next to the 65C02 datapath on Spartan-6, where a single combinational chain would not meet timing. It returns the sum together with 6502-style C/V/Z/N flags.

## Interface
- `WIDTH`, 16: operand width in bits.
- `SLICE_BITS`, 4: bits resolved per pipeline stage. `WIDTH % SLICE_BITS == 0` is mandatory; elaboration fails otherwise.
- `NSTAGES`: derived, `WIDTH/SLICE_BITS`. It is a localparam, not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; invalidates every in-flight operation.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted this cycle when high together with `in_valid`.
- `op`  in  2  operation select: 00 ADD, 01 SUB, 10 CMP, 11 INC.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `ci`  in  1  carry in (6502 convention: borrow = !ci on SUB).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result.
- `flags`  out  4  {N, V, Z, C}.

## Operation
- Effective operands, per op:
  - ADD: `a + b + ci`.
  - SUB: `a + ~b + ci`.
  - CMP: `a + ~b + 1`; `ci` is ignored.
  - INC: `a + 0 + 1`; `b` and `ci` are ignored.
- Slice k computes bits `[k*SLICE_BITS +: SLICE_BITS]`:
  - propagate `p = a_eff ^ b_eff`; generate input `g = a_eff`.
  - per-bit carry `c[i] = p[i] ? c[i-1] : g[i]`.
  - `s[i] = p[i] ^ c[i-1]`.
- Slice 0 operates combinationally on the port inputs. Rank k (k = 1..NSTAGES) then holds:
  - sum bits for slices 0..k-1;
  - the carry out of slice k-1;
  - the untouched upper operand bits;
  - the valid bit;
  - the carry into the MSB (needed for V), stored only by the final rank.
- Flags, derived from rank NSTAGES:
  - C = carry out of MSB.
  - V = carry into MSB XOR carry out of MSB.
  - Z = (sum == 0).
  - N = sum[WIDTH-1].
- Flow control uses one global advance enable: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - All ranks shift when `adv` is high. Bubbles are not compressed; the pipeline stalls as a whole.
- `flush`: all valid bits clear on the next edge. Data registers are don't-care. An input offered in the same cycle as `flush` is dropped, even though `in_ready` was high.
- Reset: all valid bits 0, `out_valid`=0, `sum`=0, `flags`=0. Reset takes effect immediately and asynchronously. Operations in flight are lost and never emitted.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only through C/V.

## Timing
- Latency is NSTAGES cycles: an operation accepted at edge n has `out_valid`=1 after edge n+NSTAGES-1. With NSTAGES=1 the result appears immediately after the accept edge.
- Throughput is one operation per cycle while `out_ready` stays high.
- Stall: when `out_valid && !out_ready`, then `in_ready`=0 in that same cycle and `sum`/`flags` hold stable.
- Simultaneous accept at the input and drain at the output is allowed and is the normal steady state.
- `in_ready` depends combinationally on `out_ready`. No path exists from `in_valid` to `in_ready`.
- Critical path: SLICE_BITS carry muxes plus the operand-select logic.

## Structure
- Package `carry_pkg` holds:
  - `op_t` enum: `OP_ADD`, `OP_SUB`, `OP_CMP`, `OP_INC`;
  - flag index constants `F_C`=0, `F_Z`=1, `F_V`=2, `F_N`=3.
- Sub-module `carry_slice #(N)` is a purely combinational N-bit mux/XOR ripple chain.
  - Ports: `ci`, `g[N]`, `p[N]`, `co[N]`, `s[N]`.
  - It is instantiated NSTAGES times inside a generate loop.
- `carry_pipe` owns the operand select, the rank registers, the handshake and the flag logic.

## Test plan
All scenarios use WIDTH=16, SLICE_BITS=4.
- ADD 0x00FF+0x0001, ci=0 -> `sum`=0x0100, flags C=0 V=0 Z=0 N=0, `out_valid` exactly 4 cycles after accept.
- ADD 0xFFFF+0x0001, ci=0 -> `sum`=0x0000, C=1, Z=1. Confirms the carry ripples through all four stages.
- SUB 0x8000−0x0001, ci=1 -> `sum`=0x7FFF, C=1, V=1, N=0. CMP on the same operands with ci=0 gives the identical result.
- Stream 6 back-to-back ops with `out_ready` low for cycles 4–7:
  - `in_ready` drops in the same cycle `out_valid && !out_ready` holds;
  - all 6 results emerge in order, with no loss and no duplicates.
- Assert `rst_n` low while 3 ops are in flight -> `out_valid`=0 immediately with `sum`=0; no result appears after reset releases.
- `flush` with 2 ops in flight plus an input offered that cycle -> none of the three is ever emitted; the next accepted op completes normally 4 cycles later.
